// File: rtl/word_serializer_pkg.sv
// Shared serial-link definitions: serializer FSM encodings, the parity-state
// encodings used by the downstream parity detector, and common widths.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } ser_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_state_t;

    localparam int GAP_CNT_W = 4;

    // Downstream detector behaviour: each 1 on x flips the running parity.
    function automatic parity_state_t parity_next(input parity_state_t cur, input logic bit_in);
        parity_state_t nxt;
        nxt = cur;
        if (bit_in) begin
            nxt = (cur == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per cycle, followed by GAP idle cycles.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    ser_state_t            state_q;
    ser_state_t            state_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [GAP_CNT_W-1:0]  gap_cnt_q;
    logic [WIDTH-1:0]      shreg_q;
    logic [WIDTH-1:0]      shreg_shifted;
    logic                  in_shift;
    logic                  at_last;
    logic                  accept;
    logic                  head_bit;

    assign in_shift = (state_q == ST_SHIFT);
    assign at_last  = in_shift && (bit_cnt_q == LAST_CNT);
    assign accept   = din_valid && din_ready;

    // The bit on x is always at the outgoing end of the register.
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_q[WIDTH-1:1]};
    assign head_bit      = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

    assign x_valid = in_shift;
    assign x_last  = at_last;
    assign x       = in_shift & head_bit;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        din_ready = 1'b0;
        state_d   = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                din_ready = 1'b1;
                state_d   = din_valid ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                if (!at_last) begin
                    state_d = ST_SHIFT;
                end else if (GAP > 0) begin
                    state_d = ST_GAP;
                end else begin
                    // With no gap the last bit cycle doubles as an accept slot.
                    din_ready = 1'b1;
                    state_d   = din_valid ? ST_SHIFT : ST_IDLE;
                end
            end
            ST_GAP: begin
                state_d = (gap_cnt_q == LAST_GAP) ? ST_IDLE : ST_GAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            if (accept) begin
                shreg_q   <= din;
                bit_cnt_q <= '0;
            end else if (at_last) begin
                shreg_q   <= '0;
                bit_cnt_q <= '0;
            end else if (in_shift) begin
                shreg_q   <= shreg_shifted;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
            end else begin
                gap_cnt_q <= '0;
            end
        end
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets data word width in bits; legal range 2..32.
REQ-002 Parameter GAP, default 1, sets idle cycles inserted after each word; legal range 0..15.
REQ-003 Parameter MSB_FIRST, default 0: 0 shifts LSB first, 1 shifts MSB first.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 din_valid  input  1  din holds a word to transfer.
REQ-008 din_ready  output  1  block can accept din this cycle.
REQ-009 x  output  1  serial bit to the downstream parity detector's x input.
REQ-010 x_valid  output  1  x carries a data bit this cycle.
REQ-011 x_last  output  1  x carries the final bit of the current word.
REQ-012 busy  output  1  state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and GAP.
REQ-014 A word SHALL transfer on any rising edge where din_valid=1 and din_ready=1; din is captured into an internal shift register at that edge.
REQ-015 din_ready SHALL be 1 in IDLE, and also in the x_last cycle of SHIFT when GAP=0; otherwise 0.
REQ-016 After a transfer, the first bit SHALL appear on x with x_valid=1 in the next cycle (latency 1).
REQ-017 In SHIFT, x_valid SHALL be 1 for exactly WIDTH consecutive cycles, presenting one bit per cycle in the order set by MSB_FIRST.
REQ-018 A bit counter of width $clog2(WIDTH) SHALL count 0..WIDTH-1; x_last=1 exactly when the count equals WIDTH-1 and state is SHIFT.
REQ-019 After the x_last cycle: GAP>0 -> GAP state for exactly GAP cycles, then IDLE; GAP=0 -> IDLE, or SHIFT directly if a new transfer occurs in the x_last cycle.
REQ-020 A transfer in the x_last cycle with GAP=0 SHALL produce the new word's first bit in the next cycle, with no bubble in x_valid.
REQ-021 When x_valid=0, x SHALL be 0 and x_last SHALL be 0.
REQ-022 din and din_valid SHALL be ignored whenever din_ready=0; no word is dropped or duplicated.
REQ-023 Illegal FSM encodings SHALL return to IDLE on the next edge.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL enter IDLE and clear counter and shift register; from the next cycle x=0, x_valid=0, x_last=0, busy=0, din_ready=1.
REQ-025 Reset asserted mid-word SHALL abandon the word; no remaining bits are emitted after reset releases.
REQ-026 A din_valid asserted during the same edge as rst_n=0 SHALL NOT be accepted.

Structure
REQ-027 State encodings (IDLE, SHIFT, GAP) SHALL be constants in the shared serial-link package, alongside the EVEN/ODD parity-state constants.
REQ-028 The block SHALL be a single module with no sub-modules; the counter and shift register are inline.

Verification
REQ-029 WIDTH=8, GAP=1, MSB_FIRST=0: transfer din=8'hB4 -> x = 0,0,1,0,1,1,0,1 over 8 cycles, x_last on the 8th, 1 GAP cycle, then din_ready=1.
REQ-030 MSB_FIRST=1, din=8'hB4 -> x = 1,0,1,1,0,1,0,0; a downstream parity detector fed by x/clk ends at z=0 (even weight 4).
REQ-031 GAP=0, back-to-back 8'hFF then 8'h01 with din_valid held high -> 16 contiguous x_valid cycles, x_last on cycles 8 and 16, no bubble.
REQ-032 GAP=3: two words offered continuously -> exactly 3 cycles of x_valid=0 and din_ready=0 between them.
REQ-033 rst_n=0 for one cycle after the 3rd bit of 8'hAA -> x_valid=0 the following cycle; IDLE with din_ready=1; no residual bits emitted.
REQ-034 din_valid toggled while busy with changing din -> only words present on accepting edges are serialized, each exactly once.
